life_sim_ctrl: RTL and testbench

LIFE_SIM_CTRL -- requirements
Module: life_sim_ctrl

---
 rtl/life_pkg.sv | 22 ++
 rtl/life_period_timer.sv | 41 ++++
 rtl/life_sim_ctrl.sv | 153 +++++++++++++++
 tb/tb_life_sim_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// ============================================================================
// Module      : life_pkg
// Description : Shared state encoding and defaults for the life simulation
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package life_pkg;

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STEP    = 2'd2,
        ST_SETTLE  = 2'd3
    } state_t;

    localparam int unsigned c_DEFAULT_SETTLE_CYC = 2;

endpackage

`default_nettype wire

// File: rtl/life_period_timer.sv
// ============================================================================
// Module      : life_period_timer
// Description : Generation period counter with a speed-shifted terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module life_period_timer #(
    parameter int unsigned BASE_PERIOD = 100000000,
    parameter int unsigned SPEED_W     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               hold,
    input  logic [SPEED_W-1:0] speed,
    output logic               terminal
);

    localparam int unsigned c_CNT_W = $clog2(BASE_PERIOD + 1);

    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        w_period;
    logic [31:0]        w_count_p1;

    // count+1 >= period avoids underflow when a large shift yields period 0
    assign w_period   = BASE_PERIOD >> speed;
    assign w_count_p1 = 32'(r_count) + 32'd1;
    assign terminal   = (w_count_p1 >= w_period);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (!hold) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/life_sim_ctrl.sv
// ============================================================================
// Module      : life_sim_ctrl
// Description : Run/pause/single-step sequencer that paces the life array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module life_sim_ctrl
    import life_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = 100000000,
    parameter int unsigned SPEED_W     = 2,
    parameter int unsigned GEN_W       = 16,
    parameter int unsigned SETTLE_CYC  = c_DEFAULT_SETTLE_CYC,
    parameter int unsigned AUTO_HALT   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_run,
    input  logic               cmd_pause,
    input  logic               cmd_single,
    input  logic               cmd_clear_gen,
    input  logic [SPEED_W-1:0] speed,
    input  logic               write_enb,
    input  logic               array_stable,
    output logic               step,
    output logic               running,
    output logic               busy,
    output logic               halted,
    output logic [GEN_W-1:0]   gen_count
);

    localparam int unsigned c_SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t             r_state;
    logic               r_run_mode;
    logic               r_single_pend;
    logic               r_pause_pend;
    logic               r_halted;
    logic [c_SET_W-1:0] r_settle_cnt;
    logic [GEN_W-1:0]   r_gen;

    logic w_terminal;
    logic w_step;
    logic w_run_mode_n;
    logic w_pause_pend_n;
    logic w_halted_n;

    life_period_timer #(
        .BASE_PERIOD (BASE_PERIOD),
        .SPEED_W     (SPEED_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (r_state != ST_RUNNING),
        .hold     (w_terminal),
        .speed    (speed),
        .terminal (w_terminal)
    );

    // STEP waits out any write so the pulse never overlaps write_enb
    assign w_step = (r_state == ST_STEP) && !write_enb;

    // Command effect while busy; pause beats run
    assign w_run_mode_n   = cmd_pause ? 1'b0 : (cmd_run ? 1'b1 : r_run_mode);
    assign w_pause_pend_n = cmd_pause ? 1'b1 : (cmd_run ? 1'b0 : r_pause_pend);
    assign w_halted_n     = (cmd_run && !cmd_pause) ? 1'b0 : r_halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_PAUSED;
            r_run_mode    <= 1'b0;
            r_single_pend <= 1'b0;
            r_pause_pend  <= 1'b0;
            r_halted      <= 1'b0;
            r_settle_cnt  <= '0;
            r_gen         <= '0;
        end else begin
            case (r_state)
                ST_PAUSED: begin
                    if (cmd_pause) begin
                        r_single_pend <= 1'b0;
                    end else if (cmd_run) begin
                        r_state       <= ST_RUNNING;
                        r_run_mode    <= 1'b1;
                        r_halted      <= 1'b0;
                        r_single_pend <= 1'b0;
                    end else if ((cmd_single || r_single_pend) && !write_enb) begin
                        r_state       <= ST_STEP;
                        r_single_pend <= 1'b0;
                    end else if (cmd_single) begin
                        r_single_pend <= 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (cmd_pause) begin
                        r_state       <= ST_PAUSED;
                        r_run_mode    <= 1'b0;
                        r_single_pend <= 1'b0;
                    end else if (w_terminal && !write_enb) begin
                        r_state <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    r_run_mode   <= w_run_mode_n;
                    r_pause_pend <= w_pause_pend_n;
                    r_halted     <= w_halted_n;
                    if (cmd_pause) r_single_pend <= 1'b0;
                    if (!write_enb) begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    r_run_mode   <= w_run_mode_n;
                    r_pause_pend <= w_pause_pend_n;
                    r_halted     <= w_halted_n;
                    if (cmd_pause) r_single_pend <= 1'b0;
                    if (r_settle_cnt == c_SET_W'(SETTLE_CYC - 1)) begin
                        r_pause_pend <= 1'b0;
                        if ((AUTO_HALT != 0) && array_stable) begin
                            r_state    <= ST_PAUSED;
                            r_run_mode <= 1'b0;
                            r_halted   <= 1'b1;
                        end else if (w_run_mode_n && !w_pause_pend_n) begin
                            r_state <= ST_RUNNING;
                        end else begin
                            r_state <= ST_PAUSED;
                        end
                    end else begin
                        r_settle_cnt <= r_settle_cnt + c_SET_W'(1);
                    end
                end
                default: r_state <= ST_PAUSED;
            endcase

            if (cmd_clear_gen) begin
                r_gen <= '0;
            end else if (w_step) begin
                r_gen <= r_gen + GEN_W'(1);
            end
        end
    end

    assign step      = w_step && !reset;
    assign busy      = (r_state == ST_STEP) || (r_state == ST_SETTLE);
    assign running   = r_run_mode;
    assign halted    = r_halted;
    assign gen_count = r_gen;

endmodule

`default_nettype wire

// File: tb/tb_life_sim_ctrl.sv
// ============================================================================
// Module      : tb_life_sim_ctrl
// Description : Self-checking bench for life_sim_ctrl against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_life_sim_ctrl;

    localparam int c_BASE   = 16;
    localparam int c_SETTLE = 2;

    logic       clk = 1'b0;
    logic       reset, cmd_run, cmd_pause, cmd_single, cmd_clear_gen;
    logic       write_enb, array_stable;
    logic [1:0] speed;

    logic        step, running, busy, halted;
    logic [15:0] gen_count;
    logic        step_s, running_s, busy_s, halted_s;
    logic [2:0]  gen_s;

    always #5 clk = ~clk;

    life_sim_ctrl #(
        .BASE_PERIOD (c_BASE), .SPEED_W (2), .GEN_W (16),
        .SETTLE_CYC (c_SETTLE), .AUTO_HALT (1)
    ) dut (
        .clk (clk), .reset (reset), .cmd_run (cmd_run), .cmd_pause (cmd_pause),
        .cmd_single (cmd_single), .cmd_clear_gen (cmd_clear_gen), .speed (speed),
        .write_enb (write_enb), .array_stable (array_stable), .step (step),
        .running (running), .busy (busy), .halted (halted), .gen_count (gen_count)
    );

    // Narrow generation counter so wrap-around is reached quickly
    life_sim_ctrl #(
        .BASE_PERIOD (c_BASE), .SPEED_W (2), .GEN_W (3),
        .SETTLE_CYC (c_SETTLE), .AUTO_HALT (1)
    ) dut_small (
        .clk (clk), .reset (reset), .cmd_run (cmd_run), .cmd_pause (cmd_pause),
        .cmd_single (cmd_single), .cmd_clear_gen (cmd_clear_gen), .speed (speed),
        .write_enb (write_enb), .array_stable (array_stable), .step (step_s),
        .running (running_s), .busy (busy_s), .halted (halted_s), .gen_count (gen_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: busy window = one step slot plus SETTLE cycles
    bit m_run, m_halted, m_single, m_active, m_stepped;
    int m_wait, m_timer, m_gen;

    int cyc_no        = 0;
    int last_step_at  = 0;
    int last_interval = 0;

    task automatic model_update();
        int per;
        per = c_BASE >> speed;
        if (reset) begin
            m_run = 0; m_halted = 0; m_single = 0; m_active = 0; m_stepped = 0;
            m_wait = 0; m_timer = 0; m_gen = 0;
            return;
        end
        if (m_active) begin
            if (cmd_pause) begin m_run = 0; m_single = 0; end
            else if (cmd_run) begin m_run = 1; m_halted = 0; end
            if (!m_stepped) begin
                if (!write_enb) begin m_gen++; m_stepped = 1; m_wait = c_SETTLE; end
            end else begin
                m_wait--;
                if (m_wait == 0) begin
                    m_active = 0;
                    m_timer  = 0;
                    if (array_stable) begin m_run = 0; m_halted = 1; end
                end
            end
        end else if (m_run) begin
            if (cmd_pause) begin m_run = 0; m_single = 0; m_timer = 0; end
            else if (m_timer >= per - 1) begin
                if (!write_enb) begin m_active = 1; m_stepped = 0; end
            end else m_timer++;
        end else begin
            if (cmd_pause) m_single = 0;
            else if (cmd_run) begin m_run = 1; m_halted = 0; m_single = 0; m_timer = 0; end
            else if ((cmd_single || m_single) && !write_enb) begin
                m_active = 1; m_stepped = 0; m_single = 0;
            end else if (cmd_single) m_single = 1;
        end
        if (cmd_clear_gen) m_gen = 0;
        m_gen = m_gen & 32'hFFFF;
    endtask

    task automatic cyc(input logic rst, input logic r, input logic p, input logic s,
                       input logic cg, input logic we, input logic st, input logic [1:0] sp);
        logic [3:0] e;
        reset = rst; cmd_run = r; cmd_pause = p; cmd_single = s; cmd_clear_gen = cg;
        write_enb = we; array_stable = st; speed = sp;
        #1;
        e = {m_active && !m_stepped && !write_enb && !reset, m_active, m_run, m_halted};
        chk("flags", {step, busy, running, halted}, e);
        chk("flags_small", {step_s, busy_s, running_s, halted_s}, e);
        chk("gen", gen_count, m_gen);
        chk("gen_small", gen_s, m_gen & 7);
        if (step) begin
            last_interval = cyc_no - last_step_at;
            last_step_at  = cyc_no;
        end
        cyc_no++;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic we, input logic st, input logic [1:0] sp);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, we, st, sp);
    endtask

    int run_at;

    initial begin
        reset = 1; cmd_run = 0; cmd_pause = 0; cmd_single = 0; cmd_clear_gen = 0;
        write_enb = 0; array_stable = 0; speed = 0;
        m_run = 0; m_halted = 0; m_single = 0; m_active = 0; m_stepped = 0;
        m_wait = 0; m_timer = 0; m_gen = 0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        // Free run at speed 0: 19-cycle spacing, three generations
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle(59, 0, 0, 0);
        chk("interval_speed0", last_interval, 19);
        chk("gen_after_3", gen_count, 3);

        // Speed 2 while running: 7-cycle spacing
        idle(40, 0, 0, 2);
        chk("interval_speed2", last_interval, 7);

        // Pause, restart, jump to speed 2 at count 10 -> step next cycle
        cyc(0, 0, 1, 0, 0, 0, 0, 2);
        idle(6, 0, 0, 0);
        run_at = cyc_no;
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle(10, 0, 0, 0);
        idle(2, 0, 0, 2);
        chk("speed_jump", last_step_at - run_at, 12);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        idle(6, 0, 0, 0);

        // Single step held off by write_enb
        cyc(0, 0, 0, 1, 0, 1, 0, 0);
        idle(5, 1, 0, 0);
        idle(6, 0, 0, 0);
        chk("single_back_paused", {busy, running}, 2'b00);

        // Auto-halt on stable array, then resume
        cyc(0, 1, 0, 0, 0, 0, 1, 1);
        idle(14, 0, 1, 1);
        chk("halted_set", {halted, running}, 2'b10);
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        idle(12, 0, 0, 1);
        chk("halt_cleared", halted, 0);

        // Pause during SETTLE, then run+pause together stays paused
        while (!step && cyc_no < 2000) idle(1, 0, 0, 1);
        idle(1, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 1);
        idle(10, 0, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 0, 1);
        idle(10, 0, 0, 1);
        chk("run_pause_paused", running, 0);

        // Clear coincident with a single step
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("clear_wins", gen_count, 0);
        idle(4, 0, 0, 0);

        // Reset during SETTLE
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        idle(2, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_in_settle", {step, busy, running, halted, gen_count}, 20'h0);
        idle(4, 0, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            logic we, st, rst;
            logic [1:0] sp;
            we  = ($urandom_range(0, 5) == 0) ? ~write_enb : write_enb;
            st  = ($urandom_range(0, 5) == 0);
            sp  = ($urandom_range(0, 60) == 0) ? 2'($urandom_range(0, 3)) : speed;
            rst = ($urandom_range(0, 600) == 0);
            cyc(rst, $urandom_range(0, 30) == 0, $urandom_range(0, 50) == 0,
                $urandom_range(0, 8) == 0, $urandom_range(0, 80) == 0, we, st, sp);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
